riscv_ex_arb: RTL and testbench
===============================

// Module: riscv_ex_arb
// PURPOSE
//  Shares one riscv_ex_pipe between two issue requesters (REQ0 = primary decode, REQ1 = secondary/assist decode).
//  Arbitrates id_ex transfers round-robin and records the owner of every op in flight in an in-order tag FIFO.
//  Routes each mem_wb result back to the requester that issued it.
//  Sits between the decode stages and riscv_ex_pipe; the pipe is strictly in-order.
// PARAMETERS
//  DEPTH    4             max ops in flight (tag FIFO entries), power of 2, >=2
//  FUNCT_W  `EX_FUNCT_W   width of the funct field
// PORTS
//  clk          in   1        clock, single domain
//  rstn         in   1        asynchronous active-low reset
//  req_rdy      in   2        per-requester op valid (bit i = REQi)
//  req_ack      out  2        per-requester op accepted
//  req_op1      in   2x32     {REQ1,REQ0} operand 1
//  req_op2      in   2x32     {REQ1,REQ0} operand 2
//  req_funct    in   2xFUNCT_W {REQ1,REQ0} function
//  ex_rdy       out  1        to pipe id_ex_rdy
//  ex_ack       in   1        from pipe id_ex_ack
//  ex_op1       out  32       to pipe id_ex_op1
//  ex_op2       out  32       to pipe id_ex_op2
//  ex_funct     out  FUNCT_W  to pipe id_ex_funct
//  wb_rdy       in   1        from pipe mem_wb_rdy
//  wb_ack       out  1        to pipe mem_wb_ack
//  wb_data      in   32       from pipe mem_wb_data
//  rsp_rdy      out  2        per-requester result valid
//  rsp_ack      in   2        per-requester result accepted
//  rsp_data     out  32       result data, shared by both rsp channels
//  err_orphan   out  1        sticky: result arrived with tag FIFO empty
// BEHAVIOUR
//  Handshake: transfer when rdy&ack high in the same cycle; producer holds rdy and data stable until ack.
//  Reset: req_ack=0, ex_rdy=0, wb_ack=0, rsp_rdy=0, err_orphan=0, FIFO empty, rr_last=REQ1 (REQ0 wins first), FSM=IDLE.
//  Arbiter FSM:
//   - IDLE: if FIFO not full and any req_rdy, pick winner (one rdy -> it; both -> the one != rr_last).
//     Drive winner's operands on ex_*, ex_rdy=1.
//     ex_ack=1 same cycle -> transfer, go IDLE. Else latch winner, go LOCKED.
//   - LOCKED: winner held, ex_* = winner operands, ex_rdy=1, no re-arbitration.
//     On ex_ack -> transfer, go IDLE.
//  On every ex transfer:
//   - req_ack[winner]=1 (combinational, =ex_ack gated by grant).
//   - push winner id into FIFO.
//   - rr_last<=winner.
//  Zero-bubble: back-to-back transfers allowed every cycle while not full.
//  FIFO full: ex_rdy=0 and no new grant, even if a pop occurs the same cycle (conservative).
//   - Full cannot arise in LOCKED, since the lock is only taken when not full.
//  Return path (head = FIFO head tag):
//   - rsp_rdy[head] = wb_rdy & !empty; other bit 0. rsp_data = wb_data (pass-through, 0 latency).
//   - wb_ack = !empty & rsp_ack[head]; pop FIFO on wb_rdy&wb_ack.
//   - Simultaneous push and pop: both occur, count unchanged.
//  Orphan: wb_rdy=1 with FIFO empty -> wb_ack=0, rsp_rdy=0, err_orphan<=1 (cleared only by reset).
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count: log2(DEPTH)+1 bits.
//  No combinational path from rsp_ack to ex_rdy, nor from ex_ack to rsp_rdy.
//  Reset mid-operation: in-flight tags discarded, lock dropped; pipe must be reset by the same rstn.
// TESTING
//  1. Only REQ0 rdy, ex_ack=1 constantly, 3 ops (op1=1,2,3) -> 3 transfers on cycles 0..2; results return on rsp_rdy[0] only, data in order.
//  2. Both rdy every cycle, ex_ack=1 -> grants alternate REQ0,REQ1,REQ0,REQ1; results routed to matching rsp bit.
//  3. REQ0 rdy, ex_ack held 0 for 3 cycles, REQ1 raises rdy in cycle 1 -> ex_* stays REQ0 operands; REQ0 wins on ex_ack; REQ1 granted next cycle.
//  4. DEPTH=4, wb_rdy=0, issue 5 ops -> 4 accepted, ex_rdy=0 while full; one wb pop -> 5th accepted the cycle after the pop.
//  5. rsp_ack[1]=0 with head tag=REQ1 -> wb_ack=0, pipe stalls; rsp_ack[1]=1 -> pop, next head tag served.
//  6. wb_rdy=1 with FIFO empty -> err_orphan=1 and stays 1; assert rstn low mid-traffic -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/riscv_ex_arb.sv
// riscv_ex_arb: round-robin sharing of one in-order riscv_ex_pipe between two
// issue requesters, with an in-order owner tag FIFO that steers results back.
`ifndef EX_FUNCT_W
`define EX_FUNCT_W 4
`endif

// state  | meaning
// IDLE   | free to arbitrate; a winner may transfer in the same cycle
// LOCKED | winner offered to the pipe without ack; held until ex_ack

module riscv_ex_arb #(
  parameter int DEPTH   = 4,
  parameter int FUNCT_W = `EX_FUNCT_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [1:0]             req_rdy,
  output logic [1:0]             req_ack,
  input  logic [63:0]            req_op1,
  input  logic [63:0]            req_op2,
  input  logic [2*FUNCT_W-1:0]   req_funct,
  output logic                   ex_rdy,
  input  logic                   ex_ack,
  output logic [31:0]            ex_op1,
  output logic [31:0]            ex_op2,
  output logic [FUNCT_W-1:0]     ex_funct,
  input  logic                   wb_rdy,
  output logic                   wb_ack,
  input  logic [31:0]            wb_data,
  output logic [1:0]             rsp_rdy,
  input  logic [1:0]             rsp_ack,
  output logic [31:0]            rsp_data,
  output logic                   err_orphan
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             rr_last;
  logic             lock_id;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] tag_mem;

  logic full, empty, grant, winner, ex_xfer, head, push, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Grant is gated by rstn in IDLE so the pipe sees no request while reset is held.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = 1'b0;
    case (state)
      IDLE: begin
        if (rstn && !full && (req_rdy != 2'b00)) begin
          grant = 1'b1;
          if (req_rdy == 2'b11) winner = ~rr_last;
          else                  winner = req_rdy[1];
          if (!ex_ack) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        grant  = 1'b1;
        winner = lock_id;
        if (ex_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ex_rdy   = grant;
  assign ex_op1   = winner ? req_op1[63:32] : req_op1[31:0];
  assign ex_op2   = winner ? req_op2[63:32] : req_op2[31:0];
  assign ex_funct = winner ? req_funct[2*FUNCT_W-1:FUNCT_W] : req_funct[FUNCT_W-1:0];
  assign ex_xfer  = grant & ex_ack;
  assign req_ack  = ex_xfer ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign push     = ex_xfer;

  assign head     = tag_mem[rd_ptr];
  assign rsp_rdy  = (wb_rdy && !empty) ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign wb_ack   = !empty && rsp_ack[head];
  assign pop      = wb_rdy & wb_ack;
  assign rsp_data = wb_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      lock_id    <= 1'b0;
      rr_last    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tag_mem    <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant && state == IDLE) lock_id <= winner;
      if (push) begin
        tag_mem[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + 1'b1;
        rr_last         <= winner;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wb_rdy && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_ex_arb.sv
// tb_riscv_ex_arb: randomized requesters and pipe around riscv_ex_arb, checked
// every cycle against a queue-based model of arbitration and result routing.
module tb_riscv_ex_arb;

  localparam int DEPTH = 4;
  localparam int FW    = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    req_rdy = '0;
  logic [1:0]    req_ack;
  logic [63:0]   req_op1 = '0;
  logic [63:0]   req_op2 = '0;
  logic [2*FW-1:0] req_funct = '0;
  logic          ex_rdy;
  logic          ex_ack = 1'b0;
  logic [31:0]   ex_op1, ex_op2;
  logic [FW-1:0] ex_funct;
  logic          wb_rdy = 1'b0;
  logic          wb_ack;
  logic [31:0]   wb_data = '0;
  logic [1:0]    rsp_rdy;
  logic [1:0]    rsp_ack = '0;
  logic [31:0]   rsp_data;
  logic          err_orphan;

  riscv_ex_arb #(.DEPTH(DEPTH), .FUNCT_W(FW)) dut (
    .clk(clk), .rstn(rstn),
    .req_rdy(req_rdy), .req_ack(req_ack),
    .req_op1(req_op1), .req_op2(req_op2), .req_funct(req_funct),
    .ex_rdy(ex_rdy), .ex_ack(ex_ack),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_funct(ex_funct),
    .wb_rdy(wb_rdy), .wb_ack(wb_ack), .wb_data(wb_data),
    .rsp_rdy(rsp_rdy), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
  } fly_t;

  fly_t fly[$];

  int checks = 0;
  int failures = 0;

  // requester-side op holding registers
  logic          rq_vld [2];
  logic [31:0]   rq_op1 [2];
  logic [31:0]   rq_op2 [2];
  logic [FW-1:0] rq_fn  [2];
  logic          wb_vld;
  logic [31:0]   seq;

  // model state
  int m_rr_last;
  bit m_locked;
  int m_lock_id;
  bit m_orphan;

  int p_new [2];
  int p_rsp [2];
  int p_exack;
  int p_wb;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] res_of(input logic [31:0] a, input logic [31:0] b,
                                         input logic [FW-1:0] f);
    return a + (b ^ {{(32-FW){1'b0}}, f});
  endfunction

  task automatic clear_bench();
    for (int i = 0; i < 2; i++) begin
      rq_vld[i] = 1'b0;
      rq_op1[i] = '0;
      rq_op2[i] = '0;
      rq_fn[i]  = '0;
    end
    wb_vld    = 1'b0;
    fly.delete();
    m_rr_last = 1;
    m_locked  = 1'b0;
    m_lock_id = 0;
    m_orphan  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ex_rdy"}, ex_rdy, 0);
    check_val({tag, "_req_ack"}, req_ack, 0);
    check_val({tag, "_wb_ack"}, wb_ack, 0);
    check_val({tag, "_rsp_rdy"}, rsp_rdy, 0);
    check_val({tag, "_err_orphan"}, err_orphan, 0);
  endtask

  task automatic step();
    bit         g;
    int         w;
    int         h;
    logic [1:0] exp_ack;
    logic [1:0] exp_rsp;
    bit         exp_wbk;
    fly_t       ent;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rq_vld[i] && ($urandom_range(99) < p_new[i])) begin
        rq_vld[i] = 1'b1;
        rq_op1[i] = seq;
        seq       = seq + 1;
        rq_op2[i] = $urandom;
        rq_fn[i]  = FW'($urandom);
      end
    end
    if (!wb_vld && fly.size() > 0 && ($urandom_range(99) < p_wb)) wb_vld = 1'b1;
    req_rdy   = {rq_vld[1], rq_vld[0]};
    req_op1   = {rq_op1[1], rq_op1[0]};
    req_op2   = {rq_op2[1], rq_op2[0]};
    req_funct = {rq_fn[1], rq_fn[0]};
    ex_ack    = ($urandom_range(99) < p_exack);
    rsp_ack   = {($urandom_range(99) < p_rsp[1]), ($urandom_range(99) < p_rsp[0])};
    wb_rdy    = wb_vld;
    wb_data   = wb_vld ? fly[0].data : $urandom;
    #1;
    g = 1'b0;
    w = 0;
    h = 0;
    if (m_locked) begin
      g = 1'b1;
      w = m_lock_id;
    end else if (fly.size() < DEPTH && (rq_vld[0] || rq_vld[1])) begin
      g = 1'b1;
      if (rq_vld[0] && rq_vld[1]) w = 1 - m_rr_last;
      else                        w = rq_vld[1] ? 1 : 0;
    end
    check_val("ex_rdy", ex_rdy, g);
    if (g) begin
      check_val("ex_op1", ex_op1, rq_op1[w]);
      check_val("ex_op2", ex_op2, rq_op2[w]);
      check_val("ex_funct", ex_funct, rq_fn[w]);
    end
    exp_ack = (g && ex_ack) ? 2'(1 << w) : 2'b00;
    check_val("req_ack", req_ack, exp_ack);
    if (fly.size() > 0) begin
      h       = fly[0].id;
      exp_rsp = wb_rdy ? 2'(1 << h) : 2'b00;
      exp_wbk = rsp_ack[h];
    end else begin
      exp_rsp = 2'b00;
      exp_wbk = 1'b0;
    end
    check_val("rsp_rdy", rsp_rdy, exp_rsp);
    check_val("wb_ack", wb_ack, exp_wbk);
    if (exp_rsp != 2'b00) check_val("rsp_data", rsp_data, fly[0].data);
    check_val("err_orphan", err_orphan, m_orphan);
    @(posedge clk);
    if (wb_rdy && exp_wbk) begin
      void'(fly.pop_front());
      wb_vld = 1'b0;
    end
    if (g && ex_ack) begin
      ent.id   = w;
      ent.data = res_of(rq_op1[w], rq_op2[w], rq_fn[w]);
      fly.push_back(ent);
      m_rr_last = w;
      m_locked  = 1'b0;
      rq_vld[w] = 1'b0;
    end else if (g) begin
      m_locked  = 1'b1;
      m_lock_id = w;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    p_new[0] = 0;   p_new[1] = 0;
    p_rsp[0] = 100; p_rsp[1] = 100;
    p_exack  = 100;
    p_wb     = 100;
    while ((fly.size() > 0 || rq_vld[0] || rq_vld[1] || m_locked) && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_bench();
    seq = 32'd1;
    // reset held with busy inputs: outputs must stay at reset values
    req_rdy = 2'b11; ex_ack = 1'b1; wb_rdy = 1'b1; rsp_ack = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    req_rdy = '0; ex_ack = 1'b0; wb_rdy = 1'b0; rsp_ack = '0;
    @(negedge clk);
    rstn = 1'b1;

    // single requester, back-to-back ops 1,2,3
    p_new[0] = 100; p_new[1] = 0; p_exack = 100; p_wb = 0;
    p_rsp[0] = 100; p_rsp[1] = 100;
    repeat (3) step();
    drain();

    // both requesters every cycle: alternation
    p_new[0] = 100; p_new[1] = 100; p_exack = 100; p_wb = 0;
    repeat (4) step();
    drain();

    // fill FIFO, hold full, then release one result at a time
    p_new[0] = 100; p_new[1] = 100; p_exack = 100; p_wb = 0;
    repeat (8) step();
    p_wb = 100;
    repeat (6) step();
    drain();

    // lock: REQ0 stalled by pipe, REQ1 arrives during the stall
    p_new[0] = 100; p_new[1] = 0; p_exack = 0; p_wb = 0;
    step();
    p_new[1] = 100;
    repeat (2) step();
    p_exack = 100;
    repeat (2) step();
    drain();

    // REQ1 consumer back-pressure stalls the return path
    p_new[0] = 100; p_new[1] = 100; p_exack = 100; p_wb = 100;
    p_rsp[0] = 100; p_rsp[1] = 0;
    repeat (10) step();
    p_rsp[1] = 100;
    repeat (4) step();
    drain();

    // randomized traffic
    for (int b = 0; b < 20; b++) begin
      p_new[0] = $urandom_range(100);
      p_new[1] = $urandom_range(100);
      p_exack  = $urandom_range(100);
      p_wb     = $urandom_range(10, 100);
      p_rsp[0] = $urandom_range(100);
      p_rsp[1] = $urandom_range(100);
      for (int k = 0; k < 100; k++) step();
    end
    drain();

    // orphan result with empty FIFO
    @(negedge clk);
    req_rdy = 2'b00; wb_rdy = 1'b1; rsp_ack = 2'b11; ex_ack = 1'b0;
    #1;
    check_val("orphan_rsp_rdy", rsp_rdy, 0);
    check_val("orphan_wb_ack", wb_ack, 0);
    @(negedge clk);
    wb_rdy = 1'b0;
    #1;
    check_val("orphan_set", err_orphan, 1);
    m_orphan = 1'b1;
    repeat (3) step();

    // async reset in the middle of traffic
    p_new[0] = 100; p_new[1] = 100; p_exack = 50; p_wb = 50;
    p_rsp[0] = 50; p_rsp[1] = 50;
    repeat (20) step();
    #2;
    req_rdy = 2'b11; ex_ack = 1'b1; wb_rdy = 1'b1; rsp_ack = 2'b11;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    req_rdy = '0; ex_ack = 1'b0; wb_rdy = 1'b0; rsp_ack = '0;
    clear_bench();
    @(negedge clk);
    rstn = 1'b1;

    // traffic after reset: REQ0 must win the first contended grant
    p_new[0] = 100; p_new[1] = 100; p_exack = 100; p_wb = 60;
    p_rsp[0] = 80; p_rsp[1] = 80;
    repeat (200) step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
